// File: rtl/throughout_first_match_monitor.sv
// Multi-channel "guard throughout (a && b)" monitor with first-match semantics
// and a bounded wait window. Each channel reports registered pass/fail pulses,
// the fail cause, the match latency and start collisions. Aggregate saturating
// counters sum the pulses across all channels.
module throughout_first_match_monitor #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MAX_WIN = 8,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned LAT_W  = $clog2(MAX_WIN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       guard,
    input  logic [NUM_CH-1:0]       cond_a,
    input  logic [NUM_CH-1:0]       cond_b,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       pass,
    output logic [NUM_CH-1:0]       fail,
    output logic [2*NUM_CH-1:0]     fail_code,
    output logic [LAT_W*NUM_CH-1:0] match_lat,
    output logic [NUM_CH-1:0]       start_drop,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt
);

    localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = CNT_W + PC_W;

    localparam logic [LAT_W-1:0] LatMax      = LAT_W'(MAX_WIN);
    localparam logic [1:0]       CodeGuard   = 2'b01;
    localparam logic [1:0]       CodeTimeout = 2'b10;

    typedef enum logic {StIdle, StWait} state_e;

    state_e           state_q [NUM_CH];
    logic [LAT_W-1:0] cnt_q   [NUM_CH];

    logic [PC_W-1:0]  pass_pop;
    logic [PC_W-1:0]  fail_pop;
    logic [SUM_W-1:0] pass_sum;
    logic [SUM_W-1:0] fail_sum;

    // busy reflects the registered WAIT state directly
    always_comb begin
        busy = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            busy[ch] = (state_q[ch] == StWait);
        end
    end

    // Per-channel attempt FSMs with registered result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= StIdle;
                cnt_q[ch]   <= '0;
            end
            pass       <= '0;
            fail       <= '0;
            fail_code  <= '0;
            match_lat  <= '0;
            start_drop <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pass[ch]       <= 1'b0;
                fail[ch]       <= 1'b0;
                // A start seen in WAIT never re-arms, even on the terminating cycle
                start_drop[ch] <= start[ch] && (state_q[ch] == StWait);
                unique case (state_q[ch])
                    StIdle: begin
                        if (start[ch]) begin
                            if (!guard[ch]) begin
                                fail[ch]               <= 1'b1;
                                fail_code[2*ch +: 2]   <= CodeGuard;
                            end else if (cond_a[ch] && cond_b[ch]) begin
                                pass[ch]                   <= 1'b1;
                                match_lat[LAT_W*ch +: LAT_W] <= '0;
                            end else begin
                                state_q[ch] <= StWait;
                                cnt_q[ch]   <= LAT_W'(1);
                            end
                        end
                    end
                    StWait: begin
                        if (!guard[ch]) begin
                            fail[ch]             <= 1'b1;
                            fail_code[2*ch +: 2] <= CodeGuard;
                            state_q[ch]          <= StIdle;
                        end else if (cond_a[ch] && cond_b[ch]) begin
                            // Match is checked before timeout so cnt==MAX_WIN can still pass
                            pass[ch]                     <= 1'b1;
                            match_lat[LAT_W*ch +: LAT_W] <= cnt_q[ch];
                            state_q[ch]                  <= StIdle;
                        end else if (cnt_q[ch] == LatMax) begin
                            fail[ch]             <= 1'b1;
                            fail_code[2*ch +: 2] <= CodeTimeout;
                            state_q[ch]          <= StIdle;
                        end else begin
                            cnt_q[ch] <= cnt_q[ch] + LAT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Popcount of this cycle's pass/fail pulses and widened sums for saturation
    always_comb begin
        pass_pop = '0;
        fail_pop = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pass_pop = pass_pop + PC_W'(pass[ch]);
            fail_pop = fail_pop + PC_W'(fail[ch]);
        end
        pass_sum = SUM_W'(pass_cnt) + SUM_W'(pass_pop);
        fail_sum = SUM_W'(fail_cnt) + SUM_W'(fail_pop);
    end

    // Saturating aggregate counters; clear wins over same-cycle increments
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clear) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            pass_cnt <= (|pass_sum[SUM_W-1:CNT_W]) ? '1 : pass_sum[CNT_W-1:0];
            fail_cnt <= (|fail_sum[SUM_W-1:CNT_W]) ? '1 : fail_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_throughout_first_match_monitor.sv
// Directed bench: stimulus pushes expected pulses into a scoreboard queue and a
// negedge monitor matches every DUT pulse against it. A second instance with
// 4-bit counters shares the inputs to exercise counter saturation.
module tb_throughout_first_match_monitor;

    localparam int NCH = 4;
    localparam int LW  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clear = 1'b0;
    logic [NCH-1:0]  start, guard, cond_a, cond_b;

    logic [NCH-1:0]    busy, pass, fail, start_drop;
    logic [2*NCH-1:0]  fail_code;
    logic [LW*NCH-1:0] match_lat;
    logic [15:0]       pass_cnt, fail_cnt;

    logic [NCH-1:0]    s_busy, s_pass, s_fail, s_start_drop;
    logic [2*NCH-1:0]  s_fail_code;
    logic [LW*NCH-1:0] s_match_lat;
    logic [3:0]        s_pass_cnt, s_fail_cnt;

    throughout_first_match_monitor dut (
        .clk(clk), .rst(rst), .clear(clear),
        .start(start), .guard(guard), .cond_a(cond_a), .cond_b(cond_b),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_lat(match_lat), .start_drop(start_drop),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    throughout_first_match_monitor #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .clear(clear),
        .start(start), .guard(guard), .cond_a(cond_a), .cond_b(cond_b),
        .busy(s_busy), .pass(s_pass), .fail(s_fail), .fail_code(s_fail_code),
        .match_lat(s_match_lat), .start_drop(s_start_drop),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 = pass (val = latency), 1 = fail (val = code), 2 = start_drop
    typedef struct {
        int cyc;
        int kind;
        int ch;
        int val;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  exp_pass = 0;
    int  exp_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] s, input logic [3:0] g,
                          input logic [3:0] a, input logic [3:0] b);
        start = s; guard = g; cond_a = a; cond_b = b;
    endtask

    // Expected pulse produced by the next clock edge
    task automatic push(input int kind, input int ch, input int val);
        ev_t e;
        e.cyc = cyc + 1; e.kind = kind; e.ch = ch; e.val = val;
        sb.push_back(e);
        if (kind == 0) exp_pass++;
        if (kind == 1) exp_fail++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_cnt();
        chk("pass_cnt", 64'(pass_cnt), 64'(exp_pass));
        chk("fail_cnt", 64'(fail_cnt), 64'(exp_fail));
        chk("sat_pass_cnt", 64'(s_pass_cnt), 64'((exp_pass > 15) ? 15 : exp_pass));
        chk("sat_fail_cnt", 64'(s_fail_cnt), 64'((exp_fail > 15) ? 15 : exp_fail));
    endtask

    // Scoreboard monitor: every observed pulse must match a queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    logic seen;
                    int   val;
                    int   idx;
                    seen = (k == 0) ? pass[ch] : (k == 1) ? fail[ch] : start_drop[ch];
                    val  = (k == 0) ? int'(match_lat[ch*LW +: LW]) :
                           (k == 1) ? int'(fail_code[ch*2 +: 2]) : 0;
                    if (seen) begin
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++) begin
                            if (idx < 0 && sb[i].cyc == cyc && sb[i].kind == k && sb[i].ch == ch)
                                idx = i;
                        end
                        tests++;
                        if (idx < 0) begin
                            fails++;
                            $display("FAIL unexpected kind%0d ch%0d: got pulse val %0d, expected none (cycle %0d)",
                                     k, ch, val, cyc);
                        end else begin
                            if (sb[idx].val != val) begin
                                fails++;
                                $display("FAIL value kind%0d ch%0d: got %0d, expected %0d (cycle %0d)",
                                         k, ch, val, sb[idx].val, cyc);
                            end
                            sb.delete(idx);
                        end
                    end
                end
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL missed kind%0d ch%0d: got no pulse, expected val %0d at cycle %0d",
                             sb[i].kind, sb[i].ch, sb[i].val, sb[i].cyc);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        // Reset state with all inputs high
        set_in(4'hF, 4'hF, 4'hF, 4'hF);
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 0);
        chk("reset_pulses", 64'({pass, fail, start_drop}), 0);
        chk("reset_code_lat", 64'({fail_code, match_lat}), 0);
        chk("reset_counters", 64'({pass_cnt, fail_cnt}), 0);
        rst = 1'b0;
        set_in(4'h0, 4'h0, 4'h0, 4'h0);
        tick();

        // Guard low on the start cycle
        set_in(4'h1, 4'h0, 4'h0, 4'h0); push(1, 0, 1); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h0); tick(); tick();
        check_cnt();

        // Immediate match on ch1
        set_in(4'h2, 4'h2, 4'h2, 4'h2); push(0, 1, 0); tick();
        chk("imm_busy1", 64'(busy[1]), 0);
        set_in(4'h0, 4'h0, 4'h0, 4'h0); tick();
        chk("imm_busy1_late", 64'(busy[1]), 0);
        tick();

        // Delayed match on ch2, with a dropped start at cycle 1
        set_in(4'h4, 4'h4, 4'h4, 4'h0); tick();
        push(2, 2, 0); tick();
        chk("delay_busy2", 64'(busy[2]), 1);
        set_in(4'h0, 4'h4, 4'h4, 4'h0); tick();
        set_in(4'h0, 4'h4, 4'h4, 4'h4); push(0, 2, 3); tick();
        tick(); tick();
        chk("delay_busy2_done", 64'(busy[2]), 0);
        chk("delay_lat_hold", 64'(match_lat[2*LW +: LW]), 3);
        set_in(4'h0, 4'h0, 4'h0, 4'h0); tick();

        // Guard drop mid-wait on ch3; start on the terminating cycle is dropped
        set_in(4'h8, 4'h8, 4'h0, 4'h0); tick();
        set_in(4'h0, 4'h8, 4'h0, 4'h0); tick();
        set_in(4'h8, 4'h0, 4'h0, 4'h0); push(1, 3, 1); push(2, 3, 0); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h0); tick(); tick();
        chk("no_rearm_busy3", 64'(busy[3]), 0);
        // Guard low beats a && b
        set_in(4'h8, 4'h8, 4'h0, 4'h0); tick();
        set_in(4'h0, 4'h8, 4'h0, 4'h0); tick();
        set_in(4'h0, 4'h0, 4'h8, 4'h8); push(1, 3, 1); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h0); tick();
        chk("guard_code_hold", 64'(fail_code[6 +: 2]), 1);
        tick();

        // Timeout on ch0 at cnt == 8
        set_in(4'h1, 4'h1, 4'h0, 4'h0); tick();
        set_in(4'h0, 4'h1, 4'h0, 4'h0); repeat (7) tick();
        push(1, 0, 2); tick();
        chk("timeout_busy0", 64'(busy[0]), 0);
        set_in(4'h0, 4'h0, 4'h0, 4'h0); tick();
        // Match exactly at cnt == 8 beats timeout
        set_in(4'h1, 4'h1, 4'h1, 4'h0); tick();
        set_in(4'h0, 4'h1, 4'h1, 4'h0); repeat (7) tick();
        set_in(4'h0, 4'h1, 4'h1, 4'h1); push(0, 0, 8); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h0); tick(); tick();
        check_cnt();

        // All channels pass together, then drive the small counter to saturation
        for (int r = 0; r < 4; r++) begin
            set_in(4'hF, 4'hF, 4'hF, 4'hF);
            for (int ch = 0; ch < NCH; ch++) push(0, ch, 0);
            tick();
            set_in(4'h0, 4'h0, 4'h0, 4'h0); tick(); tick();
            check_cnt();
        end

        // Clear on the same cycle the pass pulse is counted
        set_in(4'hF, 4'hF, 4'hF, 4'hF);
        for (int ch = 0; ch < NCH; ch++) push(0, ch, 0);
        tick();
        clear = 1'b1; set_in(4'h0, 4'h0, 4'h0, 4'h0); tick();
        clear = 1'b0; exp_pass = 0; exp_fail = 0;
        check_cnt();
        tick();
        check_cnt();

        // Reset in the middle of a wait aborts silently
        set_in(4'h2, 4'h2, 4'h0, 4'h0); tick();
        set_in(4'h0, 4'h2, 4'h0, 4'h0); tick();
        chk("pre_rst_busy1", 64'(busy[1]), 1);
        set_in(4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 0);
        tick(); tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_busy", 64'(busy), 0);
        check_cnt();

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
